// File: rtl/iir_cascade_seq.sv
// Cascade of first-order IIR sections sharing one multiplier and one adder.
// Each section: w0 = x - a*w1, y = b0*w0 + b1*w1, sequenced over three phases.
module iir_cascade_seq #(
  parameter int N_BITS    = 32,
  parameter int FRAC_BITS = 16,
  parameter int N_STAGES  = 2,
  parameter int SATURATE  = 1,
  localparam int ADDR_BITS = $clog2(3*N_STAGES+1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [N_BITS-1:0]    x_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [N_BITS-1:0]    y_o,
  input  logic                 coef_we_i,
  input  logic [ADDR_BITS-1:0] coef_addr_i,
  input  logic [N_BITS-1:0]    coef_data_i,
  output logic                 ovf_o
);
  // state | meaning
  // IDLE  | ready for a sample, coefficient writes and clear accepted
  // PH_A  | w0 = acc - a[s]*w1[s]
  // PH_B0 | p = b0[s]*w0
  // PH_B1 | acc = p + b1[s]*w1[s], w1[s] = w0, advance stage or finish
  // OUT   | result held until out_ready_i
  typedef enum logic [2:0] {IDLE, PH_A, PH_B0, PH_B1, OUT} state_t;

  localparam int SW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam logic [SW-1:0] LAST = SW'(N_STAGES-1);
  localparam logic [N_BITS-1:0] ONE = {{(N_BITS-1){1'b0}}, 1'b1} << FRAC_BITS;
  localparam int W2 = 2*N_BITS;

  state_t state, state_nx;
  logic [SW-1:0]     s;
  logic [N_BITS-1:0] acc, w0, p;
  logic [N_BITS-1:0] w1     [N_STAGES];
  logic [N_BITS-1:0] b0     [N_STAGES];
  logic [N_BITS-1:0] b1     [N_STAGES];
  logic [N_BITS-1:0] a      [N_STAGES];
  logic [N_BITS-1:0] offset;

  logic [N_BITS-1:0]    mul_x, mul_y, add_x, add_y;
  logic signed [W2-1:0] prod;
  logic [N_BITS:0]      mul_r, neg_r, add_r;
  logic                 ovf_ev;

  function automatic logic signed [W2-1:0] sx(input logic [N_BITS-1:0] v);
    return {{N_BITS{v[N_BITS-1]}}, v};
  endfunction

  // Returns {overflow, reduced value}; in range iff the top N_BITS+1 bits agree.
  function automatic logic [N_BITS:0] reduce(input logic signed [W2-1:0] v);
    logic              o;
    logic [N_BITS-1:0] r;
    o = !((&v[W2-1:N_BITS-1]) || !(|v[W2-1:N_BITS-1]));
    if (o && SATURATE != 0)
      r = v[W2-1] ? {1'b1, {(N_BITS-1){1'b0}}} : {1'b0, {(N_BITS-1){1'b1}}};
    else
      r = v[N_BITS-1:0];
    return {o, r};
  endfunction

  always_comb begin
    mul_x  = b1[s];
    mul_y  = w1[s];
    add_x  = p;
    add_y  = mul_r[N_BITS-1:0];
    ovf_ev = 1'b0;
    case (state)
      PH_A: begin
        mul_x = a[s];
        mul_y = w1[s];
      end
      PH_B0: begin
        mul_x = b0[s];
        mul_y = w0;
      end
      default: ;
    endcase
    prod  = sx(mul_x) * sx(mul_y);
    mul_r = reduce(prod >>> FRAC_BITS);
    neg_r = reduce(-sx(mul_r[N_BITS-1:0]));
    case (state)
      IDLE: begin
        add_x = x_i;
        add_y = offset;
      end
      PH_A: begin
        add_x = acc;
        add_y = neg_r[N_BITS-1:0];
      end
      default: ;
    endcase
    add_r = reduce(sx(add_x) + sx(add_y));
    case (state)
      IDLE:    ovf_ev = add_r[N_BITS] && in_valid_i && !clear_i;
      PH_A:    ovf_ev = mul_r[N_BITS] || neg_r[N_BITS] || add_r[N_BITS];
      PH_B0:   ovf_ev = mul_r[N_BITS];
      PH_B1:   ovf_ev = mul_r[N_BITS] || add_r[N_BITS];
      default: ovf_ev = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid_i && !clear_i) state_nx = PH_A;
      PH_A:    state_nx = PH_B0;
      PH_B0:   state_nx = PH_B1;
      PH_B1:   state_nx = (s == LAST) ? OUT : PH_A;
      OUT:     if (out_ready_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready_o  = (state == IDLE);
  assign out_valid_o = (state == OUT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      s      <= '0;
      acc    <= '0;
      w0     <= '0;
      p      <= '0;
      y_o    <= '0;
      ovf_o  <= 1'b0;
      offset <= '0;
      for (int i = 0; i < N_STAGES; i++) begin
        w1[i] <= '0;
        b0[i] <= ONE;
        b1[i] <= '0;
        a[i]  <= '0;
      end
    end else begin
      state <= state_nx;
      ovf_o <= ovf_o | ovf_ev;
      case (state)
        IDLE: begin
          if (clear_i) begin
            ovf_o <= 1'b0;
            for (int i = 0; i < N_STAGES; i++) w1[i] <= '0;
          end else if (in_valid_i) begin
            acc <= add_r[N_BITS-1:0];
            s   <= '0;
          end
          if (coef_we_i) begin
            for (int i = 0; i < N_STAGES; i++) begin
              if (coef_addr_i == ADDR_BITS'(3*i))   b0[i] <= coef_data_i;
              if (coef_addr_i == ADDR_BITS'(3*i+1)) b1[i] <= coef_data_i;
              if (coef_addr_i == ADDR_BITS'(3*i+2)) a[i]  <= coef_data_i;
            end
            if (coef_addr_i == ADDR_BITS'(3*N_STAGES)) offset <= coef_data_i;
          end
        end
        PH_A:  w0 <= add_r[N_BITS-1:0];
        PH_B0: p  <= mul_r[N_BITS-1:0];
        PH_B1: begin
          acc   <= add_r[N_BITS-1:0];
          w1[s] <= w0;
          if (s == LAST) y_o <= add_r[N_BITS-1:0];
          else           s   <= s + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
